// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - MEM-stage data-memory controller with fixed access latency
module mem_stage_ctrl #(
    parameter int unsigned ADDR_BASE   = 1024,
    parameter int unsigned MEM_WORDS   = 64,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] ALU_res,
    input  logic [31:0] ST_value,
    output logic        freeze,
    output logic [31:0] mem_rd_value,
    output logic        addr_err
);

    localparam int unsigned IDX_W       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [31:0] LP_BASE     = 32'(ADDR_BASE);
    localparam logic [31:0] LP_WORDS    = 32'(MEM_WORDS);
    localparam logic [3:0]  LP_CNT_INIT = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [3:0]       r_cnt;
    logic [IDX_W-1:0] r_idx;
    logic [31:0]      r_data;
    logic             r_op_wr;
    logic             r_bad;
    logic [31:0]      r_rd_value;
    logic             r_addr_err;
    logic [31:0]      r_mem [MEM_WORDS];

    logic             w_req;
    logic [31:0]      w_off;
    logic [31:0]      w_word;
    logic             w_bad;
    logic             w_commit;
    logic             w_wr_en;

    assign w_req  = mem_r_en | mem_w_en;
    assign w_off  = ALU_res - LP_BASE;
    assign w_word = w_off >> 2;
    assign w_bad  = (ALU_res < LP_BASE) || (ALU_res[1:0] != 2'b00) || (w_word >= LP_WORDS);

    assign w_commit = (r_state == S_BUSY) && (r_cnt == 4'd0);
    // A reset landing on the commit edge must abort the store as well.
    assign w_wr_en  = w_commit && r_op_wr && !r_bad && !rst;

    assign freeze       = ((r_state == S_IDLE) && w_req) || (r_state == S_BUSY);
    assign mem_rd_value = r_rd_value;
    assign addr_err     = r_addr_err;

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_idx] <= r_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_idx      <= '0;
            r_data     <= 32'd0;
            r_op_wr    <= 1'b0;
            r_bad      <= 1'b0;
            r_rd_value <= 32'd0;
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_idx   <= w_word[IDX_W-1:0];
                        r_data  <= ST_value;
                        r_op_wr <= mem_w_en;
                        r_bad   <= w_bad;
                        r_cnt   <= LP_CNT_INIT;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_op_wr) begin
                            r_rd_value <= r_bad ? 32'd0 : r_mem[r_idx];
                        end
                        r_addr_err <= r_bad;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - directed self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] ALU_res;
    logic [31:0] ST_value;
    logic        freeze;
    logic [31:0] mem_rd_value;
    logic        addr_err;

    int n_vec;
    int n_fail;

    // Access window: cycle 0 = request, 1..3 BUSY, 4 DONE, 5 following IDLE.
    localparam logic [5:0] FZ_EXP  = 6'b001111;
    localparam logic [5:0] AE_NONE = 6'b000000;
    localparam logic [5:0] AE_BAD  = 6'b010000;

    mem_stage_ctrl #(
        .ADDR_BASE  (1024),
        .MEM_WORDS  (64),
        .WAIT_CYCLES(3)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_r_en    (mem_r_en),
        .mem_w_en    (mem_w_en),
        .ALU_res     (ALU_res),
        .ST_value    (ST_value),
        .freeze      (freeze),
        .mem_rd_value(mem_rd_value),
        .addr_err    (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                              input logic hold, input logic [31:0] a2, input logic [31:0] d2,
                              output logic [5:0] fz, output logic [5:0] ae,
                              output logic [31:0] rd_done, output logic [31:0] rd_after);
        @(negedge clk);
        mem_w_en = w;
        mem_r_en = r;
        ALU_res  = a;
        ST_value = d;
        #1;
        fz[0] = freeze;
        ae[0] = addr_err;
        rd_done  = 32'd0;
        rd_after = 32'd0;
        for (int c = 1; c < 6; c++) begin
            @(negedge clk);
            if (hold && c <= 3) begin
                mem_w_en = w;
                mem_r_en = r;
                ALU_res  = a2;
                ST_value = d2;
            end else begin
                mem_w_en = 1'b0;
                mem_r_en = 1'b0;
            end
            #1;
            fz[c] = freeze;
            ae[c] = addr_err;
            if (c == 4) rd_done = mem_rd_value;
            if (c == 5) rd_after = mem_rd_value;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        ALU_res  = 32'd0;
        ST_value = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if ({freeze, addr_err, mem_rd_value} !== {1'b0, 1'b0, 32'd0}) begin
                n_fail++;
                $display("FAIL reset_idle[%0d] got freeze=%b err=%b rd=%h want 0 0 00000000",
                         c, freeze, addr_err, mem_rd_value);
            end
        end
    endtask

    task automatic test_store_load();
        logic [5:0]  fz, ae;
        logic [31:0] rdd, rda;
        run_access(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0, 32'd0, 32'd0, fz, ae, rdd, rda);
        n_vec++;
        if ({fz, ae, rdd, rda} !== {FZ_EXP, AE_NONE, 32'd0, 32'd0}) begin
            n_fail++;
            $display("FAIL store_1028 got fz=%b ae=%b rd=%h/%h want %b %b 0/0", fz, ae, rdd, rda, FZ_EXP, AE_NONE);
        end
        run_access(1'b0, 1'b1, 32'd1028, 32'd0, 1'b0, 32'd0, 32'd0, fz, ae, rdd, rda);
        n_vec++;
        if ({fz, ae, rdd, rda} !== {FZ_EXP, AE_NONE, 32'hDEADBEEF, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL load_1028 got fz=%b ae=%b rd=%h/%h want %b %b deadbeef/deadbeef", fz, ae, rdd, rda, FZ_EXP, AE_NONE);
        end
    endtask

    task automatic test_boundary();
        logic [5:0]  fz, ae;
        logic [31:0] rdd, rda;
        logic [31:0] addrs [9];
        logic        wr    [9];
        logic [31:0] wdat  [9];
        logic        bad   [9];
        logic [31:0] exprd [9];
        addrs = '{32'd1276, 32'd1280, 32'd1026, 32'd1276, 32'd1280, 32'd1026, 32'd1276, 32'd1023, 32'd1024};
        wr    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        wdat  = '{32'hCAFEF00D, 32'h55555555, 32'h66666666, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h77777777};
        bad   = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        exprd = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hCAFEF00D, 32'd0, 32'd0, 32'hCAFEF00D, 32'd0, 32'd0};
        for (int i = 0; i < 9; i++) begin
            run_access(wr[i], !wr[i], addrs[i], wdat[i], 1'b0, 32'd0, 32'd0, fz, ae, rdd, rda);
            n_vec++;
            if ({fz, ae, rdd, rda} !== {FZ_EXP, bad[i] ? AE_BAD : AE_NONE, exprd[i], exprd[i]}) begin
                n_fail++;
                $display("FAIL boundary[%0d] addr=%0d wr=%b got fz=%b ae=%b rd=%h/%h want %b %b %h/%h",
                         i, addrs[i], wr[i], fz, ae, rdd, rda, FZ_EXP, bad[i] ? AE_BAD : AE_NONE, exprd[i], exprd[i]);
            end
        end
    endtask

    task automatic test_both_enables();
        logic [5:0]  fz, ae;
        logic [31:0] rdd, rda;
        run_access(1'b0, 1'b1, 32'd1276, 32'd0, 1'b0, 32'd0, 32'd0, fz, ae, rdd, rda);
        run_access(1'b1, 1'b1, 32'd1032, 32'h12345678, 1'b0, 32'd0, 32'd0, fz, ae, rdd, rda);
        n_vec++;
        if ({fz, ae, rdd, rda} !== {FZ_EXP, AE_NONE, 32'hCAFEF00D, 32'hCAFEF00D}) begin
            n_fail++;
            $display("FAIL both_en_store got fz=%b ae=%b rd=%h/%h want %b %b cafef00d/cafef00d", fz, ae, rdd, rda, FZ_EXP, AE_NONE);
        end
        run_access(1'b0, 1'b1, 32'd1032, 32'd0, 1'b0, 32'd0, 32'd0, fz, ae, rdd, rda);
        n_vec++;
        if ({fz, ae, rdd, rda} !== {FZ_EXP, AE_NONE, 32'h12345678, 32'h12345678}) begin
            n_fail++;
            $display("FAIL both_en_load got fz=%b ae=%b rd=%h/%h want %b %b 12345678/12345678", fz, ae, rdd, rda, FZ_EXP, AE_NONE);
        end
    endtask

    task automatic test_busy_change();
        logic [5:0]  fz, ae;
        logic [31:0] rdd, rda;
        run_access(1'b1, 1'b0, 32'd1036, 32'h0BADF00D, 1'b0, 32'd0, 32'd0, fz, ae, rdd, rda);
        run_access(1'b1, 1'b0, 32'd1032, 32'h9ABCDEF0, 1'b1, 32'd1036, 32'h0, fz, ae, rdd, rda);
        n_vec++;
        if ({fz, ae, rdd, rda} !== {FZ_EXP, AE_NONE, 32'h12345678, 32'h12345678}) begin
            n_fail++;
            $display("FAIL busy_change_store got fz=%b ae=%b rd=%h/%h want %b %b 12345678/12345678", fz, ae, rdd, rda, FZ_EXP, AE_NONE);
        end
        run_access(1'b0, 1'b1, 32'd1032, 32'd0, 1'b0, 32'd0, 32'd0, fz, ae, rdd, rda);
        n_vec++;
        if (rda !== 32'h9ABCDEF0) begin
            n_fail++;
            $display("FAIL busy_change_1032 got %h want 9abcdef0", rda);
        end
        run_access(1'b0, 1'b1, 32'd1036, 32'd0, 1'b0, 32'd0, 32'd0, fz, ae, rdd, rda);
        n_vec++;
        if (rda !== 32'h0BADF00D) begin
            n_fail++;
            $display("FAIL busy_change_1036 got %h want 0badf00d", rda);
        end
    endtask

    task automatic test_reset_abort();
        logic [5:0]  fz, ae;
        logic [31:0] rdd, rda;
        run_access(1'b1, 1'b0, 32'd1040, 32'h11111111, 1'b0, 32'd0, 32'd0, fz, ae, rdd, rda);
        @(negedge clk);
        mem_w_en = 1'b1;
        ALU_res  = 32'd1040;
        ST_value = 32'hAAAA5555;
        @(negedge clk);
        mem_w_en = 1'b0;
        @(negedge clk);
        #1;
        n_vec++;
        if (freeze !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_busy_freeze got %b want 1", freeze);
        end
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_vec++;
        if ({freeze, addr_err, mem_rd_value} !== {1'b0, 1'b0, 32'd0}) begin
            n_fail++;
            $display("FAIL abort_after_reset got freeze=%b err=%b rd=%h want 0 0 00000000", freeze, addr_err, mem_rd_value);
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            n_vec++;
            if ({freeze, addr_err, mem_rd_value} !== {1'b0, 1'b0, 32'd0}) begin
                n_fail++;
                $display("FAIL abort_idle[%0d] got freeze=%b err=%b rd=%h want 0 0 00000000", c, freeze, addr_err, mem_rd_value);
            end
        end
        run_access(1'b0, 1'b1, 32'd1040, 32'd0, 1'b0, 32'd0, 32'd0, fz, ae, rdd, rda);
        n_vec++;
        if ({fz, ae, rdd, rda} !== {FZ_EXP, AE_NONE, 32'h11111111, 32'h11111111}) begin
            n_fail++;
            $display("FAIL abort_load_1040 got fz=%b ae=%b rd=%h/%h want %b %b 11111111/11111111", fz, ae, rdd, rda, FZ_EXP, AE_NONE);
        end
    endtask

    initial begin
        n_vec    = 0;
        n_fail   = 0;
        rst      = 1'b1;
        mem_r_en = 1'b0;
        mem_w_en = 1'b0;
        ALU_res  = 32'd0;
        ST_value = 32'd0;
        test_reset();
        test_store_load();
        test_boundary();
        test_both_enables();
        test_busy_change();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
